// File: rtl/synctimer_pkg.sv
// Shared types and encodings for the sync-timer subsystem.
// The adjust-sign encoding is common to the adjust driver and the local timer.
package synctimer_pkg;

  localparam int unsigned SYNCTIME_WIDTH = 64;

  typedef logic [SYNCTIME_WIDTH-1:0] synctime_t;

  localparam logic ADJ_SIGN_PLUS  = 1'b0;
  localparam logic ADJ_SIGN_MINUS = 1'b1;

endpackage

// File: rtl/synctimer_local_timer_if.sv
// Set/adjust bus of the local timer.
// The adjust driver or sync master is the master; the timer is the slave.
interface synctimer_local_timer_if #(
  parameter int unsigned TIMER_WIDTH = 64,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [TIMER_WIDTH-1:0] set_time;
  logic                   set_valid;
  logic                   adjust_sign;
  logic                   adjust_valid;
  logic                   adjust_ready;
  logic [TIMER_WIDTH-1:0] current_time;
  logic [COUNT_WIDTH-1:0] adj_plus_count;
  logic [COUNT_WIDTH-1:0] adj_minus_count;

  modport master (
    output set_time, set_valid, adjust_sign, adjust_valid,
    input  adjust_ready, current_time, adj_plus_count, adj_minus_count
  );

  modport slave (
    input  set_time, set_valid, adjust_sign, adjust_valid,
    output adjust_ready, current_time, adj_plus_count, adj_minus_count
  );
endinterface

// File: rtl/synctimer_frac_step.sv
// Fractional step accumulator: adds NUMERATOR % DENOMINATOR each cycle and
// raises a combinational carry whenever the accumulator passes DENOMINATOR.
module synctimer_frac_step #(
  parameter int unsigned NUMERATOR   = 10,
  parameter int unsigned DENOMINATOR = 3,
  parameter int unsigned ACC_WIDTH   = $clog2(DENOMINATOR) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_carry
);
  localparam int unsigned FRAC = NUMERATOR % DENOMINATOR;
  localparam int unsigned SW   = ACC_WIDTH + 1;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [SW-1:0]        w_sum;
  logic [SW-1:0]        w_acc_nxt;

  always_comb begin
    w_sum     = {1'b0, r_acc} + SW'(FRAC);
    o_carry   = (w_sum >= SW'(DENOMINATOR));
    w_acc_nxt = o_carry ? (w_sum - SW'(DENOMINATOR)) : w_sum;
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc <= '0;
    end else begin
      r_acc <= ACC_WIDTH'(w_acc_nxt);
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/synctimer_local_timer.sv
// Local time-of-day counter advancing NUMERATOR/DENOMINATOR units per clock,
// with +/-1 adjusts and absolute set. Optional stats: SYNCTIMER_LOCAL_TIMER_ADJ_STATS_EN.
module synctimer_local_timer
  import synctimer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 64,
  parameter int unsigned NUMERATOR   = 10,
  parameter int unsigned DENOMINATOR = 3,
  parameter int unsigned ADJ_HOLDOFF = 3,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset,
  synctimer_local_timer_if.slave  io_tmr
);
  localparam int unsigned ACC_WIDTH = $clog2(DENOMINATOR) + 1;
  localparam int unsigned HW        = (ADJ_HOLDOFF > 1) ? $clog2(ADJ_HOLDOFF) : 1;
  localparam logic [TIMER_WIDTH-1:0] INC = TIMER_WIDTH'(NUMERATOR / DENOMINATOR);
  localparam logic [HW-1:0] HOLD_INIT = HW'((ADJ_HOLDOFF == 0) ? 0 : ADJ_HOLDOFF - 1);

  logic [TIMER_WIDTH-1:0] r_time;
  logic [TIMER_WIDTH-1:0] w_time_nxt;
  logic [TIMER_WIDTH-1:0] w_adj;
  logic                   r_ready;
  logic                   w_ready_nxt;
  logic [HW-1:0]          r_holdoff;
  logic [HW-1:0]          w_holdoff_nxt;
  logic                   w_accept;
  logic                   w_carry;
  logic [ACC_WIDTH-1:0]   w_acc;

  synctimer_frac_step #(
    .NUMERATOR   (NUMERATOR),
    .DENOMINATOR (DENOMINATOR),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_frac_step (
    .clk     (clk),
    .reset   (reset),
    .i_clear (io_tmr.set_valid),
    .o_acc   (w_acc),
    .o_carry (w_carry)
  );

  always_comb begin
    w_accept      = io_tmr.adjust_valid && r_ready;
    w_adj         = '0;
    w_ready_nxt   = r_ready;
    w_holdoff_nxt = r_holdoff;
    if (w_accept) begin
      w_adj = (io_tmr.adjust_sign == ADJ_SIGN_MINUS) ? '1 : TIMER_WIDTH'(1);
    end
    w_time_nxt = r_time + INC + TIMER_WIDTH'(w_carry) + w_adj;
    // Set overrides everything, including an adjust accepted in the same cycle.
    if (io_tmr.set_valid) begin
      w_time_nxt    = io_tmr.set_time;
      w_ready_nxt   = 1'b1;
      w_holdoff_nxt = '0;
    end else if (w_accept && (ADJ_HOLDOFF > 0)) begin
      w_ready_nxt   = 1'b0;
      w_holdoff_nxt = HOLD_INIT;
    end else if (!r_ready) begin
      if (r_holdoff != '0) begin
        w_holdoff_nxt = r_holdoff - HW'(1);
      end else begin
        w_ready_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_time    <= '0;
      r_ready   <= 1'b0;
      r_holdoff <= '0;
    end else begin
      r_time    <= w_time_nxt;
      r_ready   <= w_ready_nxt;
      r_holdoff <= w_holdoff_nxt;
    end
  end

  assign io_tmr.current_time = r_time;
  assign io_tmr.adjust_ready = r_ready;

`ifdef SYNCTIMER_LOCAL_TIMER_ADJ_STATS_EN
  logic [COUNT_WIDTH-1:0] r_plus_cnt;
  logic [COUNT_WIDTH-1:0] r_minus_cnt;

  always_ff @(posedge clk) begin
    if (reset || io_tmr.set_valid) begin
      r_plus_cnt  <= '0;
      r_minus_cnt <= '0;
    end else if (w_accept) begin
      if (io_tmr.adjust_sign == ADJ_SIGN_PLUS) begin
        if (r_plus_cnt != '1) r_plus_cnt <= r_plus_cnt + COUNT_WIDTH'(1);
      end else begin
        if (r_minus_cnt != '1) r_minus_cnt <= r_minus_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign io_tmr.adj_plus_count  = r_plus_cnt;
  assign io_tmr.adj_minus_count = r_minus_cnt;
`else
  assign io_tmr.adj_plus_count  = '0;
  assign io_tmr.adj_minus_count = '0;
`endif

  a_acc_range: assert property (@(posedge clk) disable iff (reset)
    w_acc < ACC_WIDTH'(DENOMINATOR));
endmodule

// File: tb/tb_synctimer_local_timer.sv
// Directed bench for synctimer_local_timer across three step configurations.
module tb_synctimer_local_timer;
  import synctimer_pkg::*;

`ifdef SYNCTIMER_LOCAL_TIMER_ADJ_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: 10/3 with 2-bit stats; b: 1/1 for -1 adjust; c: 3/1 for wrap
  synctimer_local_timer_if #(.TIMER_WIDTH(64), .COUNT_WIDTH(2))  if_a ();
  synctimer_local_timer_if #(.TIMER_WIDTH(64), .COUNT_WIDTH(16)) if_b ();
  synctimer_local_timer_if #(.TIMER_WIDTH(64), .COUNT_WIDTH(16)) if_c ();

  synctimer_local_timer #(
    .TIMER_WIDTH(64), .NUMERATOR(10), .DENOMINATOR(3), .ADJ_HOLDOFF(3), .COUNT_WIDTH(2)
  ) u_dut_a (.clk(clk), .reset(reset), .io_tmr(if_a.slave));

  synctimer_local_timer #(
    .TIMER_WIDTH(64), .NUMERATOR(1), .DENOMINATOR(1), .ADJ_HOLDOFF(3), .COUNT_WIDTH(16)
  ) u_dut_b (.clk(clk), .reset(reset), .io_tmr(if_b.slave));

  synctimer_local_timer #(
    .TIMER_WIDTH(64), .NUMERATOR(3), .DENOMINATOR(1), .ADJ_HOLDOFF(3), .COUNT_WIDTH(16)
  ) u_dut_c (.clk(clk), .reset(reset), .io_tmr(if_c.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_a.set_valid = 1'b0; if_a.adjust_valid = 1'b0; if_a.set_time = '0; if_a.adjust_sign = 1'b0;
    if_b.set_valid = 1'b0; if_b.adjust_valid = 1'b0; if_b.set_time = '0; if_b.adjust_sign = 1'b0;
    if_c.set_valid = 1'b0; if_c.adjust_valid = 1'b0; if_c.set_time = '0; if_c.adjust_sign = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if_a.current_time !== 64'd0 || if_a.adjust_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: time=%0d ready=%b, expected time=0 ready=0",
               if_a.current_time, if_a.adjust_ready);
    end
    checks++;
    if (if_a.adj_plus_count !== 2'd0 || if_a.adj_minus_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_stats: plus=%0d minus=%0d, expected 0 0",
               if_a.adj_plus_count, if_a.adj_minus_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (if_a.adjust_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b expected 1", if_a.adjust_ready);
    end
  endtask

  task automatic test_free_run();
    logic [63:0] exp_t [6] = '{64'd3, 64'd6, 64'd10, 64'd13, 64'd16, 64'd20};
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (if_a.current_time !== exp_t[i]) begin
        errors++;
        $display("FAIL free_run[%0d]: time=%0d expected %0d", i, if_a.current_time, exp_t[i]);
      end
    end
  endtask

  task automatic test_adjust_plus();
    logic [63:0] exp_t [5] = '{64'd7, 64'd11, 64'd14, 64'd17, 64'd22};
    logic        exp_r [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  exp_cnt;
    do_reset();
    reset = 1'b0;
    tick();
    if_a.adjust_valid = 1'b1;
    if_a.adjust_sign  = ADJ_SIGN_PLUS;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if_a.current_time !== exp_t[i] || if_a.adjust_ready !== exp_r[i]) begin
        errors++;
        $display("FAIL adjust_plus[%0d]: time=%0d ready=%b expected time=%0d ready=%b",
                 i, if_a.current_time, if_a.adjust_ready, exp_t[i], exp_r[i]);
      end
    end
    if_a.adjust_valid = 1'b0;
    exp_cnt = STATS_ON ? 2'd2 : 2'd0;
    checks++;
    if (if_a.adj_plus_count !== exp_cnt) begin
      errors++;
      $display("FAIL adjust_plus_count: got %0d expected %0d", if_a.adj_plus_count, exp_cnt);
    end
  endtask

  task automatic test_adjust_minus();
    logic [63:0] exp_t [6] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd4, 64'd5};
    logic [15:0] exp_cnt;
    do_reset();
    reset = 1'b0;
    tick();
    if_b.adjust_valid = 1'b1;
    if_b.adjust_sign  = ADJ_SIGN_MINUS;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 4) if_b.adjust_valid = 1'b0;
      checks++;
      if (if_b.current_time !== exp_t[i]) begin
        errors++;
        $display("FAIL adjust_minus[%0d]: time=%0d expected %0d", i, if_b.current_time, exp_t[i]);
      end
    end
    exp_cnt = STATS_ON ? 16'd2 : 16'd0;
    checks++;
    if (if_b.adj_minus_count !== exp_cnt || if_b.adj_plus_count !== 16'd0) begin
      errors++;
      $display("FAIL adjust_minus_count: minus=%0d plus=%0d expected minus=%0d plus=0",
               if_b.adj_minus_count, if_b.adj_plus_count, exp_cnt);
    end
  endtask

  task automatic test_set_collision();
    do_reset();
    reset = 1'b0;
    tick();
    if_a.set_valid    = 1'b1;
    if_a.set_time     = 64'd1000;
    if_a.adjust_valid = 1'b1;
    if_a.adjust_sign  = ADJ_SIGN_PLUS;
    tick();
    if_a.set_valid    = 1'b0;
    if_a.adjust_valid = 1'b0;
    checks++;
    if (if_a.current_time !== 64'd1000 || if_a.adjust_ready !== 1'b1 ||
        if_a.adj_plus_count !== 2'd0) begin
      errors++;
      $display("FAIL set_collision: time=%0d ready=%b plus=%0d expected 1000 1 0",
               if_a.current_time, if_a.adjust_ready, if_a.adj_plus_count);
    end
    tick();
    checks++;
    if (if_a.current_time !== 64'd1003) begin
      errors++;
      $display("FAIL set_after: time=%0d expected 1003", if_a.current_time);
    end
    if_a.adjust_valid = 1'b1;
    tick();
    if_a.adjust_valid = 1'b0;
    checks++;
    if (if_a.current_time !== 64'd1007 || if_a.adjust_ready !== 1'b0) begin
      errors++;
      $display("FAIL set_adjust: time=%0d ready=%b expected 1007 0",
               if_a.current_time, if_a.adjust_ready);
    end
    if_a.set_valid = 1'b1;
    if_a.set_time  = 64'd50;
    tick();
    if_a.set_valid = 1'b0;
    checks++;
    if (if_a.current_time !== 64'd50 || if_a.adjust_ready !== 1'b1) begin
      errors++;
      $display("FAIL set_in_holdoff: time=%0d ready=%b expected 50 1",
               if_a.current_time, if_a.adjust_ready);
    end
    tick();
    checks++;
    if (if_a.current_time !== 64'd53) begin
      errors++;
      $display("FAIL set_acc_clear: time=%0d expected 53", if_a.current_time);
    end
  endtask

  task automatic test_wrap();
    synctime_t v;
    do_reset();
    reset = 1'b0;
    tick();
    if_c.set_valid = 1'b1;
    if_c.set_time  = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    if_c.set_valid = 1'b0;
    v = if_c.current_time;
    checks++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_set: time=%h expected fffffffffffffffe", v);
    end
    tick();
    checks++;
    if (if_c.current_time !== 64'd1) begin
      errors++;
      $display("FAIL wrap_1: time=%0d expected 1", if_c.current_time);
    end
    tick();
    checks++;
    if (if_c.current_time !== 64'd4) begin
      errors++;
      $display("FAIL wrap_4: time=%0d expected 4", if_c.current_time);
    end
    if_c.set_valid = 1'b1;
    if_c.set_time  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    if_c.set_valid = 1'b0;
    tick();
    checks++;
    if (if_c.current_time !== 64'd2) begin
      errors++;
      $display("FAIL wrap_max: time=%0d expected 2", if_c.current_time);
    end
  endtask

  task automatic test_stats();
    logic [1:0] exp_cnt;
    do_reset();
    reset = 1'b0;
    tick();
    if_a.adjust_valid = 1'b1;
    if_a.adjust_sign  = ADJ_SIGN_PLUS;
    repeat (17) tick();
    if_a.adjust_valid = 1'b0;
    exp_cnt = STATS_ON ? 2'd3 : 2'd0;
    checks++;
    if (if_a.adj_plus_count !== exp_cnt || if_a.adjust_ready !== 1'b0) begin
      errors++;
      $display("FAIL stats_saturate: plus=%0d ready=%b expected plus=%0d ready=0",
               if_a.adj_plus_count, if_a.adjust_ready, exp_cnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (if_a.adj_plus_count !== 2'd0 || if_a.current_time !== 64'd0 ||
        if_a.adjust_ready !== 1'b0) begin
      errors++;
      $display("FAIL stats_reset: plus=%0d time=%0d ready=%b expected 0 0 0",
               if_a.adj_plus_count, if_a.current_time, if_a.adjust_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (if_a.adjust_ready !== 1'b1 || if_a.current_time !== 64'd3) begin
      errors++;
      $display("FAIL reset_mid_holdoff: ready=%b time=%0d expected 1 3",
               if_a.adjust_ready, if_a.current_time);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_adjust_plus();
    test_adjust_minus();
    test_set_collision();
    test_wrap();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/synctimer_local_timer.md
Name: synctimer_local_timer

Overview:
- Local time-of-day counter of the sync-timer subsystem; sits directly downstream of the adjust-pulse driver.
- Advances each clk by a rational step NUMERATOR/DENOMINATOR time units.
- Accepts single-unit ±1 adjust pulses over a valid/ready handshake with programmable holdoff.
- Supports an absolute time load (set) from the sync master path; current_time feeds error measurement and timestamping logic.

Parameters:
- TIMER_WIDTH, 64, bit width of current_time; arithmetic is modulo 2^TIMER_WIDTH.
- NUMERATOR, 10, time units per DENOMINATOR clocks; must satisfy NUMERATOR >= DENOMINATOR.
- DENOMINATOR, 3, step denominator (>=1).
- ADJ_HOLDOFF, 3, cycles adjust_ready stays low after an accepted adjust (0 = no holdoff).
- COUNT_WIDTH, 16, width of optional statistics counters.

Ports:
- reset, input, 1, reset, synchronous, active-high.
- clk, input, 1, clock clk.
- set_time, input, TIMER_WIDTH, absolute time to load.
- set_valid, input, 1, load strobe (no ready; always accepted).
- adjust_sign, input, 1, 0 = +1 unit, 1 = -1 unit.
- adjust_valid, input, 1, adjust request.
- adjust_ready, output, 1, registered; adjust accepted when valid&&ready.
- current_time, output, TIMER_WIDTH, registered local time.
- adj_plus_count, output, COUNT_WIDTH, optional-feature counter (0 when compiled out).
- adj_minus_count, output, COUNT_WIDTH, optional-feature counter (0 when compiled out).

Behaviour:
- Constants:
  - INC = NUMERATOR / DENOMINATOR (integer division).
  - FRAC = NUMERATOR % DENOMINATOR.
  - acc is a fraction accumulator of width clog2(DENOMINATOR)+1, range 0..DENOMINATOR-1.
- Reset values: current_time=0, acc=0, adjust_ready=0, holdoff counter=0, both statistics counters=0. adjust_ready rises one cycle after reset deasserts.
- Normal cycle:
  - carry=(acc+FRAC >= DENOMINATOR).
  - acc <= acc+FRAC-(carry?DENOMINATOR:0).
  - current_time <= current_time + INC + carry + adj.
  - adj = +1 if an adjust is accepted with sign 0, -1 if accepted with sign 1, else 0.
- Adjust latency: an adjust accepted in cycle n is visible in current_time at n+1.
- With INC>=1, a -1 adjust at worst holds time for one cycle, so current_time is non-decreasing except on set or wrap.
- Handshake:
  - On accept with ADJ_HOLDOFF>0: adjust_ready <= 0 and holdoff <= ADJ_HOLDOFF-1.
  - While holdoff>0 it decrements; adjust_ready <= 1 in the cycle holdoff reaches 0. Result: ready is low for exactly ADJ_HOLDOFF cycles.
  - ADJ_HOLDOFF=0: ready stays 1 after reset.
  - adjust_valid while ready=0 is ignored; the upstream holds it.
- Set (cycle n): current_time(n+1)=set_time, acc <= 0, holdoff <= 0, adjust_ready <= 1, statistics counters cleared.
- Set and accepted adjust in the same cycle: set wins, the adjust is consumed but not applied and not counted.
- Wrap: all additions modulo 2^TIMER_WIDTH; there is no overflow flag. current_time=2^W-1 with increment 3 gives 2.
- Reset mid-holdoff or mid-set: reset dominates everything.
- No state machine beyond the holdoff counter (IDLE = holdoff 0 & ready, HOLD = holdoff active).

Optional Feature:
- Macro: SYNCTIMER_LOCAL_TIMER_ADJ_STATS_EN.
- Defined:
  - adj_plus_count and adj_minus_count increment on each applied +1 / -1 adjust.
  - Counters saturate at all-ones.
  - Cleared by reset and by set; registered, updated the cycle after the accept.
- Undefined: both ports are driven constant 0 and no counter registers exist.

Decomposition:
- Package synctimer_pkg:
  - typedef for time (logic [TIMER_WIDTH-1:0]).
  - adjust-sign encoding constants ADJ_SIGN_PLUS=0, ADJ_SIGN_MINUS=1, shared with the adjust driver.
- One sub-module, synctimer_frac_step:
  - Inputs: reset, clk, clear.
  - Outputs: registered acc state and combinational carry.
  - Parameterized by NUMERATOR and DENOMINATOR.

Test Plan:
- Free run: NUMERATOR=10, DENOMINATOR=3, no stimulus after reset → current_time sequence 0,3,6,10,13,16,20.
- +1 adjust: adjust_valid=1, sign=0 held → accepted when ready=1.
  - Next cycle current_time gains 1 extra unit.
  - ready low exactly 3 cycles, then the next accept happens.
  - Result: one extra unit per 4 cycles.
- -1 adjust with NUMERATOR=DENOMINATOR=1 (INC=1, FRAC=0) → current_time repeats a value once; never decreases.
- Set collision: set_valid=1, set_time=1000 in the same cycle as an accepted +1 adjust.
  - Next cycle current_time=1000.
  - Adjust dropped, statistics counters 0, ready=1.
- Wrap: set_time=2^64-2, INC=3, FRAC=0 → next values 1, 4.
- Stats (macro defined, COUNT_WIDTH=2): five +1 accepts → adj_plus_count=3 (saturated); reset → 0.
